// File: rtl/csr_regfile_ss.sv
// Machine-mode CSR file for the superscalar core: Zicsr ops with a registered
// one-cycle response, 64-bit mcycle/minstret counters and a custom scratch bank.
module csr_regfile_ss #(
  parameter int unsigned RETIRE_W    = 2,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              csr_valid_i,
  input  logic [11:0]                       csr_addr_i,
  input  logic [2:0]                        csr_cmd_i,
  input  logic [31:0]                       csr_wdata_i,
  input  logic                              csr_src_zero_i,
  input  logic [$clog2(RETIRE_W+1)-1:0]     retire_cnt_i,
  output logic                              csr_rvalid_o,
  output logic [31:0]                       csr_rdata_o,
  output logic                              csr_illegal_o
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam int unsigned SCRATCH_BASE   = 32'h7C0;

  // Architectural state
  logic        mie_q, mie_d;
  logic [29:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [29:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];

  // Response registers
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        illegal_q, illegal_d;

  // Decode
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        hit;
  logic        op_rw, op_rs, op_rc, cmd_ok;
  logic        wr_req, illegal, do_wr;

  always_comb begin
    old_val = '0;
    hit     = 1'b0;
    case (csr_addr_i)
      ADDR_MSTATUS:  begin hit = 1'b1; old_val = {28'b0, mie_q, 3'b000}; end
      ADDR_MTVEC:    begin hit = 1'b1; old_val = {mtvec_q, 2'b00}; end
      ADDR_MSCRATCH: begin hit = 1'b1; old_val = mscratch_q; end
      ADDR_MEPC:     begin hit = 1'b1; old_val = {mepc_q, 2'b00}; end
      ADDR_MCAUSE:   begin hit = 1'b1; old_val = mcause_q; end
      ADDR_MCYCLE,    ADDR_CYCLE:    begin hit = 1'b1; old_val = mcycle_q[31:0]; end
      ADDR_MCYCLEH,   ADDR_CYCLEH:   begin hit = 1'b1; old_val = mcycle_q[63:32]; end
      ADDR_MINSTRET,  ADDR_INSTRET:  begin hit = 1'b1; old_val = minstret_q[31:0]; end
      ADDR_MINSTRETH, ADDR_INSTRETH: begin hit = 1'b1; old_val = minstret_q[63:32]; end
      default: ;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (csr_addr_i == 12'(SCRATCH_BASE + i)) begin
        hit     = 1'b1;
        old_val = scratch_q[i];
      end
    end
  end

  always_comb begin
    op_rw  = (csr_cmd_i[1:0] == 2'b01);
    op_rs  = (csr_cmd_i[1:0] == 2'b10);
    op_rc  = (csr_cmd_i[1:0] == 2'b11);
    cmd_ok = (csr_cmd_i[1:0] != 2'b00);
    // Set/clear with a zero source is a pure read, so it is legal on read-only CSRs.
    wr_req  = op_rw | ((op_rs | op_rc) & ~csr_src_zero_i);
    illegal = ~cmd_ok | ~hit | (wr_req & (csr_addr_i[11:10] == 2'b11));
    do_wr   = csr_valid_i & ~illegal & wr_req;
    new_val = csr_wdata_i;
    if (op_rs) begin
      new_val = old_val | csr_wdata_i;
    end else if (op_rc) begin
      new_val = old_val & ~csr_wdata_i;
    end
  end

  always_comb begin
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    scratch_d  = scratch_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + 64'(retire_cnt_i);
    // A counter write replaces this cycle's increment; the other half keeps its old value.
    if (do_wr) begin
      case (csr_addr_i)
        ADDR_MSTATUS:   mie_d      = new_val[3];
        ADDR_MTVEC:     mtvec_d    = new_val[31:2];
        ADDR_MSCRATCH:  mscratch_d = new_val;
        ADDR_MEPC:      mepc_d     = new_val[31:2];
        ADDR_MCAUSE:    mcause_d   = new_val;
        ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], new_val};
        ADDR_MCYCLEH:   mcycle_d   = {new_val, mcycle_q[31:0]};
        ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], new_val};
        ADDR_MINSTRETH: minstret_d = {new_val, minstret_q[31:0]};
        default: ;
      endcase
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (csr_addr_i == 12'(SCRATCH_BASE + i)) begin
          scratch_d[i] = new_val;
        end
      end
    end
  end

  always_comb begin
    rvalid_d  = csr_valid_i;
    rdata_d   = rdata_q;
    illegal_d = illegal_q;
    if (csr_valid_i) begin
      rdata_d   = illegal ? 32'h0 : old_val;
      illegal_d = illegal;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_q      <= 1'b0;
      mtvec_q    <= MTVEC_RESET[31:2];
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= '0;
      end
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= scratch_d[i];
      end
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      illegal_q  <= illegal_d;
    end
  end

  assign csr_rvalid_o  = rvalid_q;
  assign csr_rdata_o   = rdata_q;
  assign csr_illegal_o = illegal_q;

endmodule
